mem_access_unit: RTL and testbench

Memory-stage block of the five-stage pipeline. It consumes the EX/MEM register outputs and performs load/store accesses on a request/ready data-memory port, generating byte enables, store-data lane replication and load extraction with sign or zero extension. It stalls the front of the pipeline while an access is outstanding and registers the MEM/WB outputs.

---
 rtl/mem_access_unit_pkg.sv | 61 ++++++
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit_lsu_load_extend.sv | 27 ++
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access stage:
// data width, access width codes, FSM states and lane helpers.
package mem_access_unit_pkg;

    localparam int WIDTH = 32;

    localparam logic [7:0] W_BYTE  = 8'h01;
    localparam logic [7:0] W_HALF  = 8'h02;
    localparam logic [7:0] W_WORD  = 8'h04;
    localparam logic [7:0] W_BYTEU = 8'h11;
    localparam logic [7:0] W_HALFU = 8'h12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic logic is_misaligned(
        input logic [7:0] w,
        input logic [1:0] off
    );
        logic m;
        m = 1'b1;
        unique case (w)
            W_BYTE, W_BYTEU: m = 1'b0;
            W_HALF, W_HALFU: m = off[0];
            W_WORD:          m = (off != 2'b00);
            default:         m = 1'b1;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] lane_be(
        input logic [7:0] w,
        input logic [1:0] off
    );
        logic [3:0] be;
        be = 4'b1111;
        unique case (w)
            W_BYTE, W_BYTEU: be = 4'b0001 << off;
            W_HALF, W_HALFU: be = off[1] ? 4'b1100 : 4'b0011;
            default:         be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [WIDTH-1:0] lane_data(
        input logic [7:0]       w,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH-1:0] r;
        r = d;
        unique case (w)
            W_BYTE, W_BYTEU: r = {4{d[7:0]}};
            W_HALF, W_HALFU: r = {2{d[15:0]}};
            default:         r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/ready port.
// master = memory-stage side, slave = memory side.
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic             dmem_req;
    logic             dmem_we;
    logic [WIDTH-1:0] dmem_addr;
    logic [3:0]       dmem_be;
    logic [WIDTH-1:0] dmem_wdata;
    logic             dmem_ready;
    logic [WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_access_unit_lsu_load_extend.sv
// Load extraction: shift the addressed lane down,
// then sign- or zero-extend by width code.
module lsu_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       off,
    input  logic [7:0]       width_code,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] shifted;

    // lane shift followed by extension
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        data    = shifted;
        unique case (width_code)
            W_BYTE:  data = {{24{shifted[7]}}, shifted[7:0]};
            W_HALF:  data = {{16{shifted[15]}}, shifted[15:0]};
            W_BYTEU: data = {24'h0, shifted[7:0]};
            W_HALFU: data = {16'h0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues load/store on the dmem port,
// stalls while outstanding, and registers MEM/WB.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             mem_valid,
    input  logic             mem_is_read_dmem,
    input  logic             mem_is_write_dmem,
    input  logic [1:0]       mem_wb_select,
    input  logic [7:0]       mem_write_width,
    input  logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_dmem_write_data,
    input  logic [4:0]       mem_rd,
    output logic             mem_stall,
    mem_access_unit_if.master dmem,
    output logic             wb_valid,
    output logic [1:0]       wb_wb_select,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_misaligned
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [7:0]       width_q, width_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [4:0]       rd_q, rd_d;
    logic [1:0]       sel_q, sel_d;

    logic             wb_valid_q, wb_valid_d;
    logic [1:0]       wb_sel_q, wb_sel_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             wb_mis_q, wb_mis_d;

    logic             mem_op;
    logic             mis;
    logic [WIDTH-1:0] ld_data;

    assign mem_op = mem_is_read_dmem | mem_is_write_dmem;
    assign mis    = is_misaligned(mem_write_width, mem_addr[1:0]);

    lsu_load_extend u_ext (
        .rdata      (dmem.dmem_rdata),
        .off        (addr_q[1:0]),
        .width_code (width_q),
        .data       (ld_data)
    );

    // next state, request latch and MEM/WB load
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        width_d    = width_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        sel_d      = sel_q;
        wb_valid_d = 1'b0;
        wb_sel_d   = wb_sel_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_mis_d   = wb_mis_q;
        mem_stall  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_valid && !mem_op) begin
                    wb_valid_d = 1'b1;
                    wb_mis_d   = 1'b0;
                    wb_data_d  = mem_addr;
                    wb_rd_d    = mem_rd;
                    wb_sel_d   = mem_wb_select;
                end else if (mem_valid && mis) begin
                    wb_valid_d = 1'b1;
                    wb_mis_d   = 1'b1;
                    wb_data_d  = '0;
                    wb_rd_d    = mem_rd;
                    wb_sel_d   = mem_wb_select;
                end else if (mem_valid) begin
                    mem_stall = 1'b1;
                    addr_d    = mem_addr;
                    width_d   = mem_write_width;
                    we_d      = mem_is_write_dmem;
                    be_d      = lane_be(mem_write_width,
                                        mem_addr[1:0]);
                    wdata_d   = lane_data(mem_write_width,
                                          mem_dmem_write_data);
                    rd_d      = mem_rd;
                    sel_d     = mem_wb_select;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (dmem.dmem_ready) begin
                    wb_valid_d = 1'b1;
                    wb_mis_d   = 1'b0;
                    wb_data_d  = we_q ? '0 : ld_data;
                    wb_rd_d    = rd_q;
                    wb_sel_d   = sel_q;
                    state_d    = ST_IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state, request and MEM/WB registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            width_q    <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            sel_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_sel_q   <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_mis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            width_q    <= width_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            sel_q      <= sel_d;
            wb_valid_q <= wb_valid_d;
            wb_sel_q   <= wb_sel_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_mis_q   <= wb_mis_d;
        end
    end

    assign dmem.dmem_req   = (state_q == ST_BUSY);
    assign dmem.dmem_we    = (state_q == ST_BUSY) & we_q;
    assign dmem.dmem_addr  = {addr_q[WIDTH-1:2], 2'b00};
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

    assign wb_valid      = wb_valid_q;
    assign wb_wb_select  = wb_sel_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign wb_misaligned = wb_mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table
// plus reset and idle sequences.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_is_read_dmem;
    logic        mem_is_write_dmem;
    logic [1:0]  mem_wb_select;
    logic [7:0]  mem_write_width;
    logic [31:0] mem_addr;
    logic [31:0] mem_dmem_write_data;
    logic [4:0]  mem_rd;
    logic        mem_stall;
    logic        wb_valid;
    logic [1:0]  wb_wb_select;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_misaligned;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .sys_clk             (clk),
        .sys_rst_n           (rst_n),
        .mem_valid           (mem_valid),
        .mem_is_read_dmem    (mem_is_read_dmem),
        .mem_is_write_dmem   (mem_is_write_dmem),
        .mem_wb_select       (mem_wb_select),
        .mem_write_width     (mem_write_width),
        .mem_addr            (mem_addr),
        .mem_dmem_write_data (mem_dmem_write_data),
        .mem_rd              (mem_rd),
        .mem_stall           (mem_stall),
        .dmem                (bus),
        .wb_valid            (wb_valid),
        .wb_wb_select        (wb_wb_select),
        .wb_rd               (wb_rd),
        .wb_data             (wb_data),
        .wb_misaligned       (wb_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd_op;
        logic        wr_op;
        logic [7:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
        logic        exp_mis;
        int          exp_stall;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[$];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rd_op, input logic wr_op,
        input logic [7:0] width, input logic [31:0] addr,
        input logic [31:0] wdata, input logic [31:0] rdata,
        input int delay, input logic [3:0] exp_be,
        input logic [31:0] exp_wdata,
        input logic [31:0] exp_wb, input logic exp_mis,
        input int exp_stall);
        vec_t v;
        v.rd_op = rd_op;   v.wr_op = wr_op;
        v.width = width;   v.addr = addr;
        v.wdata = wdata;   v.rdata = rdata;
        v.delay = delay;   v.exp_be = exp_be;
        v.exp_wdata = exp_wdata;
        v.exp_wb = exp_wb; v.exp_mis = exp_mis;
        v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic        memop;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [31:0] daddr;
        int          stalls;
        memop  = v.rd_op | v.wr_op;
        rd     = 5'(idx + 1);
        sel    = 2'(idx);
        daddr  = {v.addr[31:2], 2'b00};
        stalls = 0;
        mem_valid           = 1'b1;
        mem_is_read_dmem    = v.rd_op;
        mem_is_write_dmem   = v.wr_op;
        mem_write_width     = v.width;
        mem_addr            = v.addr;
        mem_dmem_write_data = v.wdata;
        mem_rd              = rd;
        mem_wb_select       = sel;
        #1;
        if (mem_stall) stalls++;
        chk($sformatf("v%0d req_c0", idx), 32'(bus.dmem_req), 0);
        if (memop && !v.exp_mis) begin
            for (int k = 0; k <= v.delay; k++) begin
                @(posedge clk); #1;
                mem_addr            = 32'hFFFF_FFF0 ^ 32'(k);
                mem_dmem_write_data = 32'h5555_AAAA;
                mem_write_width     = 8'h04;
                mem_is_write_dmem   = ~v.wr_op;
                mem_rd              = 5'h1F;
                bus.dmem_ready = (k == v.delay);
                bus.dmem_rdata = v.rdata;
                #1;
                if (mem_stall) stalls++;
                chk($sformatf("v%0d req", idx),
                    32'(bus.dmem_req), 1);
                chk($sformatf("v%0d we", idx),
                    32'(bus.dmem_we), 32'(v.wr_op));
                chk($sformatf("v%0d daddr", idx),
                    bus.dmem_addr, daddr);
                chk($sformatf("v%0d be", idx),
                    32'(bus.dmem_be), 32'(v.exp_be));
                if (v.wr_op)
                    chk($sformatf("v%0d wdata", idx),
                        bus.dmem_wdata, v.exp_wdata);
            end
        end
        @(posedge clk); #1;
        bus.dmem_ready    = 1'b0;
        mem_valid         = 1'b0;
        mem_is_read_dmem  = 1'b0;
        mem_is_write_dmem = 1'b0;
        chk($sformatf("v%0d stall_cycles", idx),
            32'(stalls), 32'(v.exp_stall));
        chk($sformatf("v%0d wb_valid", idx), 32'(wb_valid), 1);
        chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_wb);
        chk($sformatf("v%0d wb_mis", idx),
            32'(wb_misaligned), 32'(v.exp_mis));
        chk($sformatf("v%0d wb_rd", idx), 32'(wb_rd), 32'(rd));
        chk($sformatf("v%0d wb_sel", idx),
            32'(wb_wb_select), 32'(sel));
    endtask

    initial begin
        rst_n               = 1'b0;
        mem_valid           = 1'b0;
        mem_is_read_dmem    = 1'b0;
        mem_is_write_dmem   = 1'b0;
        mem_wb_select       = 2'b0;
        mem_write_width     = 8'h0;
        mem_addr            = 32'h0;
        mem_dmem_write_data = 32'h0;
        mem_rd              = 5'h0;
        bus.dmem_ready      = 1'b0;
        bus.dmem_rdata      = 32'h0;

        // rd, wr, width, addr, wdata, rdata, delay,
        // be, exp_wdata, exp_wb, mis, stall_cycles
        vecs.push_back(mk(0, 0, 8'h00, 32'h1234, 0, 0, 0,
            4'h0, 0, 32'h1234, 0, 0));
        vecs.push_back(mk(0, 1, 8'h01, 32'h103, 32'hA5, 0, 0,
            4'b1000, 32'hA5A5A5A5, 0, 0, 1));
        vecs.push_back(mk(1, 0, 8'h02, 32'h202, 0,
            32'h8001_7FFF, 0, 4'b1100, 0,
            32'hFFFF8001, 0, 1));
        vecs.push_back(mk(1, 0, 8'h12, 32'h202, 0,
            32'h8001_7FFF, 0, 4'b1100, 0,
            32'h00008001, 0, 1));
        vecs.push_back(mk(1, 0, 8'h04, 32'h40, 0,
            32'hDEADBEEF, 3, 4'b1111, 0,
            32'hDEADBEEF, 0, 4));
        vecs.push_back(mk(1, 0, 8'h04, 32'h6, 0, 0, 0,
            4'h0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 8'h01, 32'h301, 0,
            32'h1122_80FF, 0, 4'b0010, 0,
            32'hFFFFFF80, 0, 1));
        vecs.push_back(mk(1, 0, 8'h11, 32'h301, 0,
            32'h1122_80FF, 0, 4'b0010, 0,
            32'h00000080, 0, 1));
        vecs.push_back(mk(0, 1, 8'h02, 32'h12, 32'h1234_BEEF,
            0, 1, 4'b1100, 32'hBEEFBEEF, 0, 0, 2));
        vecs.push_back(mk(0, 1, 8'h04, 32'h20, 32'hCAFEF00D,
            0, 0, 4'b1111, 32'hCAFEF00D, 0, 0, 1));
        vecs.push_back(mk(1, 0, 8'h03, 32'h0, 0, 0, 0,
            4'h0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 8'h02, 32'h5, 0, 0, 0,
            4'h0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 8'h01, 32'h0, 32'h12,
            32'hFFFF_FFFF, 0, 4'b0001, 32'h12121212,
            0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h12, 32'h10, 32'h0000_7E81,
            0, 2, 4'b0011, 32'h7E817E81, 0, 0, 3));
        vecs.push_back(mk(1, 0, 8'h04, 32'h104, 0,
            32'h0BAD_F00D, 0, 4'b1111, 0,
            32'h0BADF00D, 0, 1));

        #3;
        chk("rst req", 32'(bus.dmem_req), 0);
        chk("rst we", 32'(bus.dmem_we), 0);
        chk("rst be", 32'(bus.dmem_be), 0);
        chk("rst addr", bus.dmem_addr, 0);
        chk("rst wdata", bus.dmem_wdata, 0);
        chk("rst stall", 32'(mem_stall), 0);
        chk("rst wb_valid", 32'(wb_valid), 0);
        chk("rst wb_mis", 32'(wb_misaligned), 0);
        chk("rst wb_data", wb_data, 0);
        chk("rst wb_rd", 32'(wb_rd), 0);
        chk("rst wb_sel", 32'(wb_wb_select), 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], i);

        // bubble: nothing valid, nothing written back
        #1;
        chk("idle stall", 32'(mem_stall), 0);
        @(posedge clk); #1;
        chk("idle wb_valid", 32'(wb_valid), 0);
        chk("idle req", 32'(bus.dmem_req), 0);

        // reset in the middle of an outstanding load
        mem_valid        = 1'b1;
        mem_is_read_dmem = 1'b1;
        mem_write_width  = 8'h04;
        mem_addr         = 32'h80;
        mem_rd           = 5'd7;
        #1;
        chk("abort stall_c0", 32'(mem_stall), 1);
        @(posedge clk); #1;
        mem_valid        = 1'b0;
        mem_is_read_dmem = 1'b0;
        chk("abort req_busy", 32'(bus.dmem_req), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort req", 32'(bus.dmem_req), 0);
        chk("abort wb_valid", 32'(wb_valid), 0);
        chk("abort stall", 32'(mem_stall), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst req", 32'(bus.dmem_req), 0);
        run_vec(vecs[9], 9);
        run_vec(vecs[4], 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
